// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master, MSB first, one DATA_W-bit word per nCS frame.
// SCK is a registered data output divided down from sys_clk, never a clock.
module spi_master_ctrl #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 4
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              nCS
);

    localparam int PH_A   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PH_MAX = (PH_A > CS_GAP) ? PH_A : CS_GAP;
    localparam int PW     = $clog2(PH_MAX) + 1;
    localparam int DW     = $clog2(CLK_DIV) + 1;
    localparam int TW     = $clog2(2 * DATA_W) + 1;

    localparam logic [PW-1:0] SETUP_T = PW'(CS_SETUP - 1);
    localparam logic [PW-1:0] HOLD_T  = PW'(CS_HOLD - 1);
    // The idle cycle before a new accept is the last gap cycle.
    localparam logic [PW-1:0] GAP_T   = PW'((CS_GAP > 1) ? CS_GAP - 2 : 0);
    localparam logic [DW-1:0] DIV_T   = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TGL_T   = TW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       ph_q, ph_d;
    logic [DW-1:0]       div_q, div_d;
    logic [TW-1:0]       tgl_q, tgl_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rxs_q, rxs_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                ncs_q, ncs_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= '0;
            div_q   <= '0;
            tgl_q   <= '0;
            tx_q    <= '0;
            rxs_q   <= '0;
            rx_q    <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            div_q   <= div_d;
            tgl_q   <= tgl_d;
            tx_q    <= tx_d;
            rxs_q   <= rxs_d;
            rx_q    <= rx_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            ncs_q   <= ncs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        div_d   = div_q;
        tgl_d   = tgl_q;
        tx_d    = tx_q;
        rxs_d   = rxs_q;
        rx_d    = rx_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        ncs_d   = ncs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    tx_d    = tx_data;
                    mosi_d  = tx_data[DATA_W-1];
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    ph_d    = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (ph_q == SETUP_T) begin
                    ph_d    = '0;
                    div_d   = '0;
                    tgl_d   = '0;
                    state_d = XFER;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            XFER: begin
                if (div_q == DIV_T) begin
                    div_d = '0;
                    sck_d = !sck_q;
                    if (!sck_q) begin
                        rxs_d = {rxs_q[DATA_W-2:0], MISO};
                    end else if (tgl_q != TGL_T) begin
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[DATA_W-2];
                    end
                    if (tgl_q == TGL_T) begin
                        ph_d    = '0;
                        state_d = HOLD;
                    end else begin
                        tgl_d = tgl_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (ph_q == HOLD_T) begin
                    ncs_d  = 1'b1;
                    mosi_d = 1'b0;
                    done_d = 1'b1;
                    rx_d   = rxs_q;
                    ph_d   = '0;
                    if (CS_GAP > 1) begin
                        state_d = GAP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            GAP: begin
                if (ph_q == GAP_T) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign SCK     = sck_q;
    assign MOSI    = mosi_q;
    assign nCS     = ncs_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized frames checked against a frame-level model
// (expected word, nCS low time, SCK rise count/latency, bits seen on MOSI).
module tb_spi_master_ctrl;

    localparam int D = 8, C = 8, S = 4, H = 4, G = 4;
    localparam int LOW_A = S + 2 * D * C + H;
    localparam int LAT_A = S + C;
    localparam int LOW_B = 1 + 2 * D * 2 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start_a = 1'b0;
    logic [7:0] tx_a = '0;
    logic       busy_a, done_a, sck_a, mosi_a, ncs_a, miso_a;
    logic [7:0] rx_a;

    logic       start_b = 1'b0;
    logic [7:0] tx_b = '0;
    logic       busy_b, done_b, sck_b, mosi_b, ncs_b, miso_b;
    logic [7:0] rx_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_master_ctrl dut_a (
        .sys_clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a), .SCK(sck_a),
        .MOSI(mosi_a), .MISO(miso_a), .nCS(ncs_a)
    );

    spi_master_ctrl #(
        .DATA_W(8), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)
    ) dut_b (
        .sys_clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b), .SCK(sck_b),
        .MOSI(mosi_b), .MISO(miso_b), .nCS(ncs_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observation of dut_a, sampled on the falling edge
    int         rises_a = 0, lowlen_a = 0, last_low_a = 0, lat_a = 0;
    int         highlen_a = 0, dones_a = 0, falls_a = 0;
    int         gaps_q[$];
    logic [7:0] mbits_a = '0;
    bit         sck_pa = 1'b0, ncs_pa = 1'b1, tog = 1'b0;
    int         mode = 2;
    logic [7:0] slv = '0;

    always @(negedge clk) begin
        tog = ~tog;
        if (ncs_a === 1'b0) begin
            if (ncs_pa) begin
                lowlen_a = 0; rises_a = 0; mbits_a = '0; lat_a = 0;
                falls_a++;
                gaps_q.push_back(highlen_a);
            end
            lowlen_a++;
            if (sck_a === 1'b1 && !sck_pa) begin
                if (rises_a == 0) lat_a = lowlen_a - 1;
                if (rises_a < 8) mbits_a[7-rises_a] = mosi_a;
                rises_a++;
            end
            highlen_a = 0;
        end else begin
            if (!ncs_pa) last_low_a = lowlen_a;
            highlen_a++;
        end
        if (done_a === 1'b1) dones_a++;
        sck_pa = (sck_a === 1'b1);
        ncs_pa = (ncs_a !== 1'b0);
    end

    // Slave model: loopback, fixed word shifted MSB first, or free toggling
    always_comb begin
        miso_a = 1'b0;
        case (mode)
            0: miso_a = mosi_a;
            1: if (rises_a < 8) miso_a = slv[7-rises_a];
            default: miso_a = tog;
        endcase
    end

    assign miso_b = mosi_b;

    int cyc_b = 0, lowlen_b = 0, last_low_b = 0;
    bit sck_pb = 1'b0, ncs_pb = 1'b1;
    int rt_q[$];

    always @(negedge clk) begin
        cyc_b++;
        if (ncs_b === 1'b0) begin
            if (ncs_pb) begin
                lowlen_b = 0;
                rt_q.delete();
            end
            lowlen_b++;
            if (sck_b === 1'b1 && !sck_pb) rt_q.push_back(cyc_b);
        end else if (!ncs_pb) begin
            last_low_b = lowlen_b;
        end
        sck_pb = (sck_b === 1'b1);
        ncs_pb = (ncs_b !== 1'b0);
    end

    task automatic frame_a(input logic [7:0] tx, input int md,
                           input logic [7:0] sw, input int pulse_at);
        int n, d0, f0;
        logic [7:0] er;
        mode = md;
        slv  = sw;
        er   = (md == 0) ? tx : sw;
        d0   = dones_a;
        @(posedge clk); #1;
        start_a = 1'b1; tx_a = tx;
        @(posedge clk); #1;
        start_a = 1'b0; tx_a = 8'($urandom);
        chk("busy_acc", busy_a, 1);
        chk("ncs_fall", ncs_a, 0);
        n = 0;
        while (done_a !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (n == pulse_at) begin
                start_a = 1'b1; tx_a = 8'hFF;
            end else begin
                start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        chk("done_seen", done_a, 1);
        chk("rx_data", rx_a, er);
        @(posedge clk); #1;
        chk("done_pulse", done_a, 0);
        chk("ncs_low_len", last_low_a, LOW_A);
        chk("sck_rises", rises_a, D);
        chk("first_rise", lat_a, LAT_A);
        chk("mosi_bits", mbits_a, tx);
        f0 = falls_a;
        n = 0;
        while (busy_a !== 1'b0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_end", busy_a, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("no_requeue", falls_a - f0, 0);
        chk("one_done", dones_a - d0, 1);
        chk("rx_hold", rx_a, er);
    endtask

    task automatic frame_b(input logic [7:0] tx);
        int n;
        @(posedge clk); #1;
        start_b = 1'b1; tx_b = tx;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b_done", done_b, 1);
        chk("b_rx", rx_b, tx);
        @(posedge clk); #1;
        chk("b_ncs_low", last_low_b, LOW_B);
        chk("b_rises", rt_q.size(), 8);
        if (rt_q.size() == 8) begin
            chk("b_per_first", rt_q[1] - rt_q[0], 4);
            chk("b_per_last", rt_q[7] - rt_q[6], 4);
        end
        chk("b_idle", busy_b, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f0, gsz, d0;
        logic [7:0] v;

        // T1: reset with MISO toggling
        mode = 2;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ncs", ncs_a, 1);
        chk("rst_sck", sck_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rx", rx_a, 0);
        chk("rst_ncs_b", ncs_b, 1);
        rst = 1'b0;

        // T2 loopback, T3 slave word, then random frames with stray start pulses
        frame_a(8'hA5, 0, 8'h00, 60);
        frame_a(8'h81, 1, 8'h3C, 30);
        for (int i = 0; i < 6; i++) begin
            frame_a(8'($urandom), int'($urandom_range(0, 1)), 8'($urandom),
                    int'($urandom_range(5, 120)));
        end

        // T4: start held high -> back-to-back frames
        v    = 8'($urandom);
        mode = 0;
        f0   = falls_a;
        gsz  = gaps_q.size();
        @(posedge clk); #1;
        start_a = 1'b1; tx_a = v;
        n = 0;
        while (falls_a < f0 + 3 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        start_a = 1'b0;
        chk("b2b_frames", falls_a - f0, 3);
        chk("b2b_gap1", gaps_q[gsz+1], G);
        chk("b2b_gap2", gaps_q[gsz+2], G);
        n = 0;
        while (busy_a !== 1'b0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_idle", busy_a, 0);
        chk("b2b_rx", rx_a, v);

        // T5: reset after the 3rd SCK rise
        mode = 1;
        slv  = 8'($urandom);
        d0   = dones_a;
        @(posedge clk); #1;
        start_a = 1'b1; tx_a = 8'($urandom);
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (rises_a < 3 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_rises", rises_a, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ncs", ncs_a, 1);
        chk("abort_sck", sck_a, 0);
        chk("abort_mosi", mosi_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_rx", rx_a, 0);
        repeat (200) @(posedge clk);
        #1;
        chk("abort_nodone", dones_a - d0, 0);
        chk("abort_ncs_hi", ncs_a, 1);
        frame_a(8'($urandom), 0, 8'h00, 40);

        // T6: fast instance, loopback
        frame_b(8'h5A);
        for (int i = 0; i < 3; i++) frame_b(8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
